// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^WIDTH + x^(WIDTH-1) + 1 PRBS stream.
// Seeds from the line, verifies predictions, then free-runs and counts errors.
module prbs_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic             data_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam int SW = $clog2(WIDTH + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);
   localparam logic [ERR_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      SEED,
      VERIFY,
      LOCKED
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [SW-1:0]    seed_q, seed_d;
   logic [MW-1:0]    match_q, match_d;
   logic [LW-1:0]    miss_q, miss_d;
   logic             locked_d;
   logic             err_d;
   logic [ERR_W-1:0] cnt_d;
   logic             inc;
   logic             pred;
   logic [WIDTH-1:0] s_data;
   logic [WIDTH-1:0] s_pred;

   assign pred   = s_q[WIDTH-1] ^ s_q[WIDTH-2];
   assign s_data = {s_q[WIDTH-2:0], data_i};
   assign s_pred = {s_q[WIDTH-2:0], pred};

   // Register state, shift register, counters and all outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= SEED;
         s_q       <= '0;
         seed_q    <= '0;
         match_q   <= '0;
         miss_q    <= '0;
         locked_o  <= 1'b0;
         err_o     <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         seed_q    <= seed_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked_o  <= locked_d;
         err_o     <= err_d;
         err_cnt_o <= cnt_d;
      end
   end

   // Next-state logic: seed, verify predictions, then free-run on pred.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      seed_d   = seed_q;
      match_d  = match_q;
      miss_d   = miss_q;
      locked_d = locked_o;
      err_d    = 1'b0;
      inc      = 1'b0;
      if (valid_i) begin
         unique case (state_q)
            SEED: begin
               s_d = s_data;
               if (seed_q == SEED_LAST) begin
                  seed_d = '0;
                  if (|s_data) begin
                     state_d = VERIFY;
                     match_d = '0;
                  end
               end else begin
                  seed_d = seed_q + SW'(1);
               end
            end
            VERIFY: begin
               s_d = s_data;
               if (data_i == pred) begin
                  if (match_q == LOCK_LAST) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     match_d  = '0;
                     miss_d   = '0;
                  end else begin
                     match_d = match_q + MW'(1);
                  end
               end else begin
                  state_d = SEED;
                  seed_d  = '0;
                  match_d = '0;
               end
            end
            LOCKED: begin
               s_d = s_pred;
               if (data_i == pred) begin
                  miss_d = '0;
               end else begin
                  err_d = 1'b1;
                  inc   = 1'b1;
                  if (miss_q == LOSS_LAST) begin
                     state_d  = SEED;
                     locked_d = 1'b0;
                     seed_d   = '0;
                     match_d  = '0;
                     miss_d   = '0;
                  end else begin
                     miss_d = miss_q + LW'(1);
                  end
               end
            end
            default: begin
               state_d = SEED;
            end
         endcase
      end
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc && (err_cnt_o != CNT_MAX)) begin
         cnt_d = err_cnt_o + ERR_W'(1);
      end else begin
         cnt_d = err_cnt_o;
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: random PRBS stimulus against a
// queue-based model of the checker rules, plus directed timing checks.
module tb_prbs_checker;

   localparam int WIDTH    = 4;
   localparam int LOCK_CNT = 8;
   localparam int LOSS_CNT = 4;
   localparam int ERR_W    = 3;
   localparam int CMAX     = 7;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             clear_i;
   logic             valid_i;
   logic             data_i;
   logic             locked_o;
   logic             err_o;
   logic [ERR_W-1:0] err_cnt_o;

   prbs_checker #(
      .WIDTH   (WIDTH),
      .LOCK_CNT(LOCK_CNT),
      .LOSS_CNT(LOSS_CNT),
      .ERR_W   (ERR_W)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .locked_o (locked_o),
      .err_o    (err_o),
      .err_cnt_o(err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   bit refs[15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
   int tx = 0;

   // model: window of the last WIDTH shifted bits, oldest first
   bit hist[$];
   int m_mode;
   int m_seed;
   int m_match;
   int m_miss;
   bit e_locked;
   bit e_err;
   int e_cnt;

   function automatic bit nb();
      bit b;
      b = refs[tx % 15];
      tx++;
      return b;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (WIDTH) hist.push_back(1'b0);
      m_mode   = 0;
      m_seed   = 0;
      m_match  = 0;
      m_miss   = 0;
      e_locked = 0;
      e_err    = 0;
      e_cnt    = 0;
   endtask

   task automatic shift_in(input bit b);
      hist.push_back(b);
      void'(hist.pop_front());
   endtask

   task automatic model_beat(input bit v, input bit d, input bit clr);
      bit p;
      bit any;
      e_err = 0;
      if (v) begin
         p = hist[0] ^ hist[1];
         if (m_mode == 0) begin
            shift_in(d);
            m_seed++;
            if (m_seed == WIDTH) begin
               m_seed = 0;
               any = 0;
               foreach (hist[i]) any |= hist[i];
               if (any) begin
                  m_mode  = 1;
                  m_match = 0;
               end
            end
         end else if (m_mode == 1) begin
            shift_in(d);
            if (d == p) begin
               m_match++;
               if (m_match == LOCK_CNT) begin
                  m_mode   = 2;
                  e_locked = 1;
                  m_miss   = 0;
               end
            end else begin
               m_mode  = 0;
               m_seed  = 0;
               m_match = 0;
            end
         end else begin
            shift_in(p);
            if (d != p) begin
               e_err = 1;
               if (e_cnt < CMAX) e_cnt++;
               m_miss++;
               if (m_miss == LOSS_CNT) begin
                  m_mode   = 0;
                  e_locked = 0;
                  m_seed   = 0;
                  m_match  = 0;
                  m_miss   = 0;
               end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (clr) e_cnt = 0;
   endtask

   // drive at negedge, update model at posedge, return at next negedge
   task automatic step(input bit v, input bit d, input bit clr);
      valid_i = v;
      data_i  = d;
      clear_i = clr;
      @(posedge clk_i);
      model_beat(v, d, clr);
      @(negedge clk_i);
      valid_i = 1'b0;
      clear_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      clear_i = 1'b0;
      data_i  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      clear_i = 1'b0;
      data_i  = 1'b0;
      model_reset();
      #1;
      checks++;
      if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 3'd0) begin
         failures++;
         $display("FAIL reset_async: got l=%b e=%b c=%0d want 0 0 0",
                  locked_o, err_o, err_cnt_o);
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) step(1'b0, 1'b1, 1'b0);
      checks++;
      if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 3'd0) begin
         failures++;
         $display("FAIL reset_idle: got l=%b e=%b c=%0d want 0 0 0",
                  locked_o, err_o, err_cnt_o);
      end
   endtask

   task automatic test_lock_acq();
      bit el;
      do_reset();
      tx = 0;
      for (int k = 1; k <= 112; k++) begin
         step(1'b1, nb(), 1'b0);
         el = (k >= 12);
         checks++;
         if (locked_o !== el || err_o !== 1'b0 || err_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL lock_acq beat %0d: got l=%b e=%b c=%0d want %b 0 0",
                     k, locked_o, err_o, err_cnt_o, el);
         end
         checks++;
         if (locked_o !== e_locked || err_o !== e_err ||
             err_cnt_o !== e_cnt[ERR_W-1:0]) begin
            failures++;
            $display("FAIL lock_acq_model beat %0d: got %b %b %0d want %b %b %0d",
                     k, locked_o, err_o, err_cnt_o, e_locked, e_err, e_cnt);
         end
      end
   endtask

   task automatic test_single_err();
      int pos;
      bit b;
      int pulses;
      pos = $urandom_range(3, 15);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         b = nb();
         if (k == pos) b = ~b;
         step(1'b1, b, 1'b0);
         if (err_o === 1'b1) pulses++;
         checks++;
         if (err_o !== (k == pos) || locked_o !== 1'b1) begin
            failures++;
            $display("FAIL single_err beat %0d: got e=%b l=%b want %b 1",
                     k, err_o, locked_o, (k == pos));
         end
      end
      checks++;
      if (pulses != 1 || err_cnt_o !== 3'd1) begin
         failures++;
         $display("FAIL single_err_count: got pulses=%0d c=%0d want 1 1",
                  pulses, err_cnt_o);
      end
   endtask

   task automatic test_loss_of_lock();
      int n;
      step(1'b1, nb(), 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, ~nb(), 1'b0);
         checks++;
         if (err_o !== 1'b1 || err_cnt_o !== 3'(k) ||
             locked_o !== (k < 4)) begin
            failures++;
            $display("FAIL loss_bad %0d: got e=%b c=%0d l=%b want 1 %0d %b",
                     k, err_o, err_cnt_o, locked_o, k, (k < 4));
         end
      end
      n = 0;
      while (locked_o !== 1'b1 && n < 40) begin
         step(1'b1, nb(), 1'b0);
         n++;
         checks++;
         if (locked_o !== e_locked || err_o !== e_err ||
             err_cnt_o !== e_cnt[ERR_W-1:0]) begin
            failures++;
            $display("FAIL relock_model beat %0d: got %b %b %0d want %b %b %0d",
                     n, locked_o, err_o, err_cnt_o, e_locked, e_err, e_cnt);
         end
      end
      checks++;
      if (n != 12) begin
         failures++;
         $display("FAIL relock_beats: got %0d want 12", n);
      end
   endtask

   task automatic test_invalid();
      bit b;
      bit el;
      do_reset();
      for (int k = 1; k <= 200; k++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (locked_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_stream beat %0d: got l=%b e=%b want 0 0",
                     k, locked_o, err_o);
         end
      end
      do_reset();
      tx = $urandom_range(0, 14);
      for (int k = 1; k <= 30; k++) begin
         b = nb();
         if (k == 8) b = ~b;
         step(1'b1, b, 1'b0);
         el = (k >= 20);
         checks++;
         if (locked_o !== el || locked_o !== e_locked) begin
            failures++;
            $display("FAIL verify_miss beat %0d: got l=%b want %b model %b",
                     k, locked_o, el, e_locked);
         end
      end
   endtask

   task automatic test_gaps_clear();
      int beats;
      int cyc;
      bit v;
      do_reset();
      tx = $urandom_range(0, 14);
      beats = 0;
      cyc = 0;
      while (beats < 30 && cyc < 300) begin
         v = ($urandom_range(0, 9) >= 3);
         if (v) begin
            step(1'b1, nb(), 1'b0);
            beats++;
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         cyc++;
         checks++;
         if (locked_o !== (beats >= 12) || locked_o !== e_locked ||
             err_o !== 1'b0) begin
            failures++;
            $display("FAIL gaps beat %0d cyc %0d: got l=%b e=%b want %b 0",
                     beats, cyc, locked_o, err_o, (beats >= 12));
         end
      end
      step(1'b1, ~nb(), 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (err_o !== 1'b0 || err_cnt_o !== 3'd1 || err_cnt_o !== e_cnt[ERR_W-1:0]) begin
         failures++;
         $display("FAIL gap_err: got e=%b c=%0d want 0 1", err_o, err_cnt_o);
      end
      step(1'b1, nb(), 1'b0);
      step(1'b1, ~nb(), 1'b1);
      checks++;
      if (err_o !== 1'b1 || err_cnt_o !== 3'd0 || locked_o !== 1'b1) begin
         failures++;
         $display("FAIL clear_err: got e=%b c=%0d l=%b want 1 0 1",
                  err_o, err_cnt_o, locked_o);
      end
   endtask

   task automatic test_saturation_reset();
      int n;
      do_reset();
      tx = $urandom_range(0, 14);
      n = 0;
      while (locked_o !== 1'b1 && n < 40) begin
         step(1'b1, nb(), 1'b0);
         n++;
      end
      checks++;
      if (n != 12) begin
         failures++;
         $display("FAIL sat_lock: got %0d beats want 12", n);
      end
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, ~nb(), 1'b0);
         checks++;
         if (err_o !== 1'b1 || err_cnt_o !== 3'((k < CMAX) ? k : CMAX) ||
             err_cnt_o !== e_cnt[ERR_W-1:0]) begin
            failures++;
            $display("FAIL sat_err %0d: got e=%b c=%0d want 1 %0d",
                     k, err_o, err_cnt_o, (k < CMAX) ? k : CMAX);
         end
         repeat ($urandom_range(1, 3)) step(1'b1, nb(), 1'b0);
      end
      checks++;
      if (err_cnt_o !== 3'd7 || locked_o !== 1'b1) begin
         failures++;
         $display("FAIL sat_hold: got c=%0d l=%b want 7 1",
                  err_cnt_o, locked_o);
      end
      step(1'b1, ~nb(), 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 3'd0) begin
         failures++;
         $display("FAIL mid_reset: got l=%b e=%b c=%0d want 0 0 0",
                  locked_o, err_o, err_cnt_o);
      end
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      n = 0;
      while (locked_o !== 1'b1 && n < 40) begin
         step(1'b1, nb(), 1'b0);
         n++;
      end
      checks++;
      if (n != 12) begin
         failures++;
         $display("FAIL post_reset_lock: got %0d beats want 12", n);
      end
   endtask

   initial begin
      test_reset();
      test_lock_acq();
      test_single_err();
      test_loss_of_lock();
      test_invalid();
      test_gaps_clear();
      test_saturation_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
